// File: rtl/spi_master_if.sv
// spi_master_if -- bundle of the request/response and serial-bus signals of
// the SPI master.
//   master modport (spi_master side):
//     in : start, slave_sel[1:0], mode_cpol, mode_cpha, tx_word[15:0], MISO
//     out: rx_data[15:0], busy, done, ss[3:0], sck, cpol, cpoh, MOSI
//   slave modport: the same signals with directions reversed (host + slaves).
interface spi_master_if;
    logic        start;
    logic [1:0]  slave_sel;
    logic        mode_cpol;
    logic        mode_cpha;
    logic [15:0] tx_word;
    logic [15:0] rx_data;
    logic        busy;
    logic        done;
    logic [3:0]  ss;
    logic        sck;
    logic        cpol;
    logic        cpoh;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  start, slave_sel, mode_cpol, mode_cpha, tx_word, MISO,
        output rx_data, busy, done, ss, sck, cpol, cpoh, MOSI
    );

    modport slave (
        output start, slave_sel, mode_cpol, mode_cpha, tx_word, MISO,
        input  rx_data, busy, done, ss, sck, cpol, cpoh, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// spi_master -- 32-bit SPI transaction engine: 16-bit command (LSB first)
// followed by a 16-bit response phase whose MISO bits land in rx_data.
//   clk   : system clock, everything changes on its rising edge
//   reset : synchronous active-high reset
//   bus   : spi_master_if.master (request inputs, status outputs, SPI pins)
// Parameter CLK_DIV (2..255) is the sck half-period in clk cycles.
// Every output comes straight from a register; the combinational process
// computes the next value of each.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;             // clk cycles within a half-period
    logic [5:0]  edge_cnt, edge_cnt_n;   // sck edges already produced, 0..63
    logic        cpol_q, cpol_n;
    logic        cpha_q, cpha_n;
    logic [15:0] tx_q, tx_n;
    logic [15:0] rx_q, rx_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        sck_q, sck_n;
    logic        mosi_q, mosi_n;
    logic [3:0]  ss_q, ss_n;

    logic        div_hit;
    logic [4:0]  bit_idx;
    logic        leading;

    // The edge about to be produced is k = edge_cnt+1, so its bit index
    // (k-1)/2 is edge_cnt/2 and it is a leading edge when edge_cnt is even.
    assign div_hit = (cnt == DIV_LAST);
    assign bit_idx = edge_cnt[5:1];
    assign leading = ~edge_cnt[0];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        edge_cnt_n = edge_cnt;
        cpol_n     = cpol_q;
        cpha_n     = cpha_q;
        tx_n       = tx_q;
        rx_n       = rx_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        sck_n      = sck_q;
        mosi_n     = mosi_q;
        ss_n       = ss_q;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                ss_n   = 4'b1111;
                sck_n  = cpol_q;
                mosi_n = 1'b0;
                if (bus.start) begin
                    state_n = SETUP;
                    cnt_n   = '0;
                    cpol_n  = bus.mode_cpol;
                    cpha_n  = bus.mode_cpha;
                    tx_n    = bus.tx_word;
                    busy_n  = 1'b1;
                    ss_n    = ~(4'b0001 << bus.slave_sel);
                    sck_n   = bus.mode_cpol;
                    // cpha=0 slaves sample on the first edge, so bit 0 must
                    // already be on the wire during setup.
                    mosi_n  = bus.mode_cpha ? 1'b0 : bus.tx_word[0];
                end
            end

            SETUP: begin
                if (div_hit) begin
                    state_n    = XFER;
                    cnt_n      = '0;
                    edge_cnt_n = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            XFER: begin
                if (div_hit) begin
                    cnt_n = '0;
                    sck_n = ~sck_q;
                    if (leading == cpha_q) begin
                        // Launch edge: trailing for cpha=0 (next bit),
                        // leading for cpha=1 (current bit).
                        if (cpha_q)
                            mosi_n = bit_idx[4] ? 1'b0 : tx_q[bit_idx[3:0]];
                        else if (bit_idx < 5'd15)
                            mosi_n = tx_q[bit_idx[3:0] + 4'd1];
                        else
                            mosi_n = 1'b0;
                    end else if (bit_idx[4]) begin
                        // Capture edge in the response phase; command-phase
                        // samples are dropped.
                        rx_n[bit_idx[3:0]] = bus.MISO;
                    end
                    if (edge_cnt == 6'd63) begin
                        state_n = HOLD;
                        mosi_n  = 1'b0;
                    end else begin
                        edge_cnt_n = edge_cnt + 6'd1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            HOLD: begin
                mosi_n = 1'b0;
                if (div_hit) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    ss_n    = 4'b1111;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            DONE: begin
                // busy covers the done cycle; start is only looked at in IDLE.
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ss_q     <= 4'b1111;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            edge_cnt <= edge_cnt_n;
            cpol_q   <= cpol_n;
            cpha_q   <= cpha_n;
            tx_q     <= tx_n;
            rx_q     <= rx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            sck_q    <= sck_n;
            mosi_q   <= mosi_n;
            ss_q     <= ss_n;
        end
    end

    assign bus.rx_data = rx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ss      = ss_q;
    assign bus.sck     = sck_q;
    assign bus.cpol    = cpol_q;
    assign bus.cpoh    = cpha_q;
    assign bus.MOSI    = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- randomized bench for spi_master (CLK_DIV=2). A behavioural
// SPI slave watches sck/ss, serves a 32-bit stream (junk then response) and
// records the MOSI bits it sees; a monitor scores every done pulse.
module tb_spi_master;
    localparam int D   = 2;
    localparam int LAT = 66 * D + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_if bus ();

    spi_master #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  sel;
        logic        cpol;
        logic        cpha;
        logic [15:0] tx;
        logic [15:0] resp;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] resp_q[$];
    int          done_q[$];

    // ---------------- behavioural slave ----------------
    logic [31:0] stream;
    logic [31:0] mosi_cap;
    int          edges = 0;
    int          mosi_bad = 0;
    int          ss_bad = 0;
    logic [3:0]  ss_seen;
    logic        prev_sck = 1'b0, prev_act = 1'b0, prev_mosi = 1'b0;
    logic        s_act, s_lead;
    int          s_b;

    always @(negedge clk) begin
        s_act = (bus.ss != 4'hF);
        if (!s_act) begin
            bus.MISO = 1'($urandom);
        end else if (!prev_act) begin
            stream[15:0] = 16'($urandom);
            if (resp_q.size() > 0) stream[31:16] = resp_q.pop_front();
            else                   stream[31:16] = 16'($urandom);
            edges    = 0;
            mosi_cap = '0;
            mosi_bad = 0;
            ss_bad   = 0;
            ss_seen  = bus.ss;
            if (!bus.cpoh) bus.MISO = stream[0];
        end else if (bus.sck != prev_sck) begin
            edges++;
            s_lead = edges[0];
            s_b    = (edges - 1) / 2;
            if (bus.MOSI != prev_mosi && s_lead != bus.cpoh) mosi_bad++;
            if (!bus.cpoh) begin
                if (s_lead)       mosi_cap[s_b] = bus.MOSI;
                else if (s_b < 31) bus.MISO = stream[s_b + 1];
            end else begin
                if (s_lead) bus.MISO = stream[s_b];
                else        mosi_cap[s_b] = bus.MOSI;
            end
        end else if (bus.MOSI != prev_mosi) begin
            mosi_bad++;
        end
        if (s_act && prev_act && bus.ss != ss_seen) ss_bad++;
        prev_sck  = bus.sck;
        prev_act  = s_act;
        prev_mosi = bus.MOSI;
    end

    // ---------------- done monitor / scoreboard ----------------
    int         cyc = 0, done_cnt = 0, rise_cyc = 0;
    logic       prev_busy = 1'b0;
    txn_t       mt;
    logic [3:0] ss_exp;

    always @(negedge clk) begin
        cyc++;
        if (bus.busy && !prev_busy) rise_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mt     = exp_q.pop_front();
                ss_exp = ~(4'b0001 << mt.sel);
                check("latency", cyc - rise_cyc + 1, LAT);
                check("rx_data", bus.rx_data, mt.resp);
                check("mosi_stream", mosi_cap, {16'h0000, mt.tx});
                check("sck_edges", edges, 64);
                check("ss_select", ss_seen, ss_exp);
                check("ss_stable", ss_bad, 0);
                check("mosi_timing", mosi_bad, 0);
                check("ss_at_done", bus.ss, 4'hF);
                check("busy_at_done", bus.busy, 1);
                check("cpol_out", bus.cpol, mt.cpol);
                check("cpoh_out", bus.cpoh, mt.cpha);
            end
        end
        prev_busy = bus.busy;
    end

    // ---------------- stimulus ----------------
    task automatic go(input logic [1:0] sel, input logic cp, input logic ch,
                      input logic [15:0] tx, input logic [15:0] resp, input bit poke);
        int   n;
        int   d0;
        txn_t t;
        t = '{sel: sel, cpol: cp, cpha: ch, tx: tx, resp: resp};
        exp_q.push_back(t);
        resp_q.push_back(resp);
        d0 = done_cnt;
        bus.slave_sel = sel;
        bus.mode_cpol = cp;
        bus.mode_cpha = ch;
        bus.tx_word   = tx;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        check("busy_after_start", bus.busy, 1);
        check("sck_setup", bus.sck, cp);
        while (!bus.done && n < 4 * LAT) begin
            if (poke && n == D + 10) begin
                bus.start     = 1'b1;
                bus.slave_sel = 2'($urandom);
                bus.mode_cpol = ~cp;
                bus.mode_cpha = ~ch;
                bus.tx_word   = ~tx;
            end
            if (poke && n == D + 11) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_ss", bus.ss, 4'hF);
        check("idle_mosi", bus.MOSI, 0);
        check("idle_sck", bus.sck, cp);
        if (poke) begin
            repeat (4) @(negedge clk);
            check("start_not_queued", bus.busy, 0);
        end
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int   n;
        int   d0;
        int   k;
        txn_t t;
        logic [15:0] r;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.slave_sel = 2'd0;
        bus.mode_cpol = 1'b0;
        bus.mode_cpha = 1'b0;
        bus.tx_word   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ss", bus.ss, 4'hF);
        check("rst_sck", bus.sck, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rx", bus.rx_data, 16'h0000);
        check("rst_mosi", bus.MOSI, 0);
        check("rst_cpol", bus.cpol, 0);
        check("rst_cpoh", bus.cpoh, 0);
        reset = 1'b0;
        @(negedge clk);

        // reset wins over a simultaneous start
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.slave_sel = 2'd1;
        bus.mode_cpol = 1'b1;
        @(negedge clk);
        check("rst_vs_start_busy", bus.busy, 0);
        check("rst_vs_start_ss", bus.ss, 4'hF);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_vs_start_later", bus.busy, 0);

        // directed modes
        go(2'd2, 1'b0, 1'b0, 16'h0005, 16'h0605, 1'b0);
        go(2'd2, 1'b1, 1'b1, 16'h0005, 16'h0605, 1'b0);
        go(2'd1, 1'b0, 1'b1, 16'h00A3, 16'hA4A3, 1'b0);
        go(2'd3, 1'b1, 1'b0, 16'h00A3, 16'hA4A3, 1'b0);

        // reset in the middle of XFER
        t = '{sel: 2'($urandom), cpol: 1'b1, cpha: 1'b0, tx: 16'($urandom), resp: 16'h1234};
        exp_q.push_back(t);
        resp_q.push_back(t.resp);
        bus.slave_sel = t.sel;
        bus.mode_cpol = t.cpol;
        bus.mode_cpha = t.cpha;
        bus.tx_word   = t.tx;
        bus.start     = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        n = 0;
        while (edges < 20 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_edge20", (edges >= 20), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ss", bus.ss, 4'hF);
        check("abort_sck", bus.sck, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rx", bus.rx_data, 16'h0000);
        check("abort_cpol", bus.cpol, 0);
        check("abort_mosi", bus.MOSI, 0);
        reset = 1'b0;
        t = exp_q.pop_back();
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        go(2'd0, 1'b0, 1'b1, 16'hBEEF, 16'hC0DE, 1'b0);

        // start pulsed mid-transfer with scrambled inputs
        go(2'd1, 1'b1, 1'b0, 16'h5A3C, 16'h9D71, 1'b1);

        // start held high across three back-to-back transactions
        bus.slave_sel = 2'd1;
        bus.mode_cpol = 1'b0;
        bus.mode_cpha = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            exp_q.push_back('{sel: 2'd1, cpol: 1'b0, cpha: 1'b1, tx: 16'(i + 1), resp: r});
            resp_q.push_back(r);
        end
        k = done_q.size();
        bus.tx_word = 16'h0001;
        bus.start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.tx_word = 16'(i + 2);
            n = 1;
            while (!bus.done && n < 4 * LAT) begin
                @(negedge clk);
                n++;
            end
            if (!bus.done) check("b2b_timeout", 0, 1);
            if (i == 2) bus.start = 1'b0;
            @(negedge clk);
            check("b2b_idle_one_cycle", bus.busy, 0);
        end
        check("b2b_count", done_q.size() - k, 3);
        if (done_q.size() - k == 3) begin
            check("b2b_gap1", done_q[k + 1] - done_q[k], 66 * D + 2);
            check("b2b_gap2", done_q[k + 2] - done_q[k + 1], 66 * D + 2);
        end
        repeat (4) @(negedge clk);
        check("b2b_stopped", bus.busy, 0);

        // random traffic
        for (int i = 0; i < 8; i++)
            go(2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: sck half-period in clk cycles (legal range 2..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  transaction request; sampled only in IDLE.
REQ-005 slave_sel  input  2  target slave index 0..3; latched on accepted start.
REQ-006 mode_cpol  input  1  requested clock polarity; latched on accepted start.
REQ-007 mode_cpha  input  1  requested clock phase; latched on accepted start.
REQ-008 tx_word  input  16  command word; bits [7:0] are the register address; latched on accepted start.
REQ-009 rx_data  output  16  response word captured from MISO.
REQ-010 busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-011 done  output  1  one-clk pulse at transaction end.
REQ-012 ss  output  4  active-low slave selects; one-hot-low for the latched slave_sel.
REQ-013 sck  output  1  serial clock to slaves.
REQ-014 cpol  output  1  latched polarity, fed to slave cpol input.
REQ-015 cpoh  output  1  latched phase, fed to slave cpoh input.
REQ-016 MOSI  output  1  serial data to slaves.
REQ-017 MISO  input  1  serial data from slaves, sampled as-is.

Function
REQ-018 FSM states IDLE, SETUP, XFER, HOLD, DONE; all outputs registered.
REQ-019 IDLE -> SETUP when start=1; slave_sel, mode_cpol, mode_cpha and tx_word latch in that same cycle.
REQ-020 SETUP lasts CLK_DIV cycles: ss[sel]=0, sck=cpol, MOSI=tx_word[0] if cpha=0, else 0.
REQ-021 XFER lasts 64*CLK_DIV cycles: sck toggles every CLK_DIV cycles, giving edges k=1..64 (odd=leading, even=trailing); bit index b=(k-1)/2, 0..31.
REQ-022 Bits 0..15 form the command phase: MOSI carries tx_word[b], LSB first; bits 16..31 form the response phase: MOSI=0.
REQ-023 cpha=0: MISO sampled on leading edges; MOSI advances to bit b+1 on trailing edges.
REQ-024 cpha=1: MOSI set to bit b on leading edges; MISO sampled on trailing edges.
REQ-025 Samples for b>=16 load rx_data[b-16] (LSB first); command-phase samples are discarded.
REQ-026 HOLD lasts CLK_DIV cycles: sck=cpol, ss unchanged, MOSI=0.
REQ-027 DONE lasts 1 cycle: done=1, ss=4'b1111, rx_data final, then IDLE.
REQ-028 Latency: done is high exactly 66*CLK_DIV+1 cycles after the start-accept edge.
REQ-029 rx_data is updated only while busy and holds its value until the next transaction reaches its response phase.
REQ-030 start while busy is ignored and not queued; input changes while busy have no effect.
REQ-031 In IDLE: sck=latched cpol, ss=4'b1111, MOSI=0, busy=0.
REQ-032 start held high continuously: a new transaction begins the cycle after DONE, and IDLE lasts 1 cycle.

Reset
REQ-033 reset=1 forces IDLE on the next edge, including mid-transfer: ss=4'b1111, sck=0, cpol=0, cpoh=0, MOSI=0, busy=0, done=0, rx_data=16'h0000, counters=0.
REQ-034 reset has priority over start in the same cycle, and the transaction is not accepted.
REQ-035 A transfer aborted by reset produces no done pulse.

Verification
REQ-036 CLK_DIV=2, mode 0, sel=2, tx_word=16'h0005, slave model returns 16'h0605 -> ss=4'b1011 during the transfer, 64 sck edges, rx_data=16'h0605, done at cycle 133.
REQ-037 Mode 3 (cpol=1, cpha=1), same stimulus -> sck idles high, MOSI changes on falling edges, MISO sampled on rising edges, rx_data=16'h0605.
REQ-038 Modes 1 and 2, tx_word=16'h00A3, slave model returns 16'hA4A3 -> rx_data=16'hA4A3 in both; sck idle level equals cpol.
REQ-039 start pulsed at the 10th cycle of XFER -> ignored; exactly one done pulse; tx bit stream unchanged.
REQ-040 reset asserted at XFER edge 20 -> next cycle ss=4'b1111, sck=0, busy=0, rx_data=0, no done; a following start completes normally.
REQ-041 start held high for 3 transactions, tx_word 16'h0001/16'h0002/16'h0003 -> three done pulses 134 cycles apart (CLK_DIV=2) with matching rx_data.
